// File: rtl/stream_pkt_tx.sv
// Packet transmitter: turns a byte-length command plus a raw word stream into a
// framed payload/keep/last/cnt stream with the final partial word masked.
module stream_pkt_tx #(
  parameter int payload_width = 32,
  parameter int DATA_BYTE_WD  = payload_width / 8,
  parameter int DATA_CNT_WD   = $clog2(DATA_BYTE_WD),
  parameter int LEN_WD        = 16
) (
  input  logic                     i_hclk,
  input  logic                     i_hrstn,
  input  logic                     i_cmd_valid,
  input  logic [LEN_WD-1:0]        i_cmd_len,
  output logic                     o_cmd_ready,
  input  logic                     i_data_valid,
  input  logic [payload_width-1:0] i_data_payload,
  output logic                     o_data_ready,
  output logic                     o_dest_valid,
  output logic [payload_width-1:0] o_dest_payload,
  output logic [DATA_BYTE_WD-1:0]  o_dest_keepin,
  output logic                     o_dest_last,
  output logic [DATA_CNT_WD-1:0]   o_dest_cnt,
  input  logic                     i_dest_ready,
  output logic                     o_busy,
  output logic                     o_pkt_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                     state_q;
  logic [LEN_WD-1:0]          rem_q;
  logic                       dest_valid_q;
  logic [payload_width-1:0]   dest_payload_q;
  logic [DATA_BYTE_WD-1:0]    dest_keep_q;
  logic                       dest_last_q;
  logic [DATA_CNT_WD-1:0]     dest_cnt_q;

  logic                       cmd_ready_s;
  logic                       data_ready_s;
  logic                       cmd_fire_s;
  logic                       data_fire_s;
  logic                       final_beat_s;
  logic [payload_width-1:0]   payload_d;
  logic [DATA_BYTE_WD-1:0]    keep_d;
  logic [DATA_CNT_WD-1:0]     cnt_d;

  // Handshake qualifiers and the contents of the next beat built from the incoming word
  always_comb begin
    cmd_ready_s  = (state_q == ST_IDLE);
    data_ready_s = (state_q == ST_SEND) & (~dest_valid_q | i_dest_ready);
    cmd_fire_s   = i_cmd_valid & cmd_ready_s;
    data_fire_s  = i_data_valid & data_ready_s;
    final_beat_s = (rem_q <= LEN_WD'(DATA_BYTE_WD));
    keep_d       = {DATA_BYTE_WD{1'b0}};
    payload_d    = {payload_width{1'b0}};
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      if (final_beat_s) begin
        keep_d[b] = (rem_q > LEN_WD'(b));
      end else begin
        keep_d[b] = 1'b1;
      end
      // Bytes beyond the packet end go out as zero so stale data never leaks
      payload_d[b*8 +: 8] = keep_d[b] ? i_data_payload[b*8 +: 8] : 8'h00;
    end
    if (final_beat_s) begin
      cnt_d = rem_q[DATA_CNT_WD-1:0] - DATA_CNT_WD'(1);
    end else begin
      cnt_d = DATA_CNT_WD'(DATA_BYTE_WD - 1);
    end
  end

  // Packet FSM, remaining-byte counter and the output beat register
  always_ff @(posedge i_hclk or negedge i_hrstn) begin
    if (!i_hrstn) begin
      state_q        <= ST_IDLE;
      rem_q          <= {LEN_WD{1'b0}};
      dest_valid_q   <= 1'b0;
      dest_payload_q <= {payload_width{1'b0}};
      dest_keep_q    <= {DATA_BYTE_WD{1'b0}};
      dest_last_q    <= 1'b0;
      dest_cnt_q     <= {DATA_CNT_WD{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Zero-length commands are swallowed without producing a packet
          if (cmd_fire_s && (i_cmd_len != {LEN_WD{1'b0}})) begin
            rem_q   <= i_cmd_len;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (data_fire_s) begin
            if (final_beat_s) begin
              rem_q   <= {LEN_WD{1'b0}};
              state_q <= ST_IDLE;
            end else begin
              rem_q   <= rem_q - LEN_WD'(DATA_BYTE_WD);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rem_q   <= {LEN_WD{1'b0}};
        end
      endcase

      if (data_fire_s) begin
        dest_valid_q   <= 1'b1;
        dest_payload_q <= payload_d;
        dest_keep_q    <= keep_d;
        dest_last_q    <= final_beat_s;
        dest_cnt_q     <= cnt_d;
      end else if (i_dest_ready) begin
        dest_valid_q   <= 1'b0;
      end
    end
  end

  assign o_cmd_ready    = cmd_ready_s;
  assign o_data_ready   = data_ready_s;
  assign o_dest_valid   = dest_valid_q;
  assign o_dest_payload = dest_payload_q;
  assign o_dest_keepin  = dest_keep_q;
  assign o_dest_last    = dest_last_q;
  assign o_dest_cnt     = dest_cnt_q;
  assign o_busy         = (state_q == ST_SEND) | dest_valid_q;
  assign o_pkt_done     = dest_valid_q & dest_last_q & i_dest_ready;

endmodule

// File: tb/tb_stream_pkt_tx.sv
// Directed self-checking bench for stream_pkt_tx (32-bit payload, 16-bit length).
module tb_stream_pkt_tx;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic        data_valid;
  logic [31:0] data_payload;
  logic        data_ready;
  logic        dest_valid;
  logic [31:0] dest_payload;
  logic [3:0]  dest_keepin;
  logic        dest_last;
  logic [1:0]  dest_cnt;
  logic        dest_ready;
  logic        busy;
  logic        pkt_done;

  int n_checks = 0;
  int n_errors = 0;
  int beats    = 0;
  int dones    = 0;
  int beats_base;
  int dones_base;

  stream_pkt_tx dut (
    .i_hclk         (clk),
    .i_hrstn        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .i_cmd_len      (cmd_len),
    .o_cmd_ready    (cmd_ready),
    .i_data_valid   (data_valid),
    .i_data_payload (data_payload),
    .o_data_ready   (data_ready),
    .o_dest_valid   (dest_valid),
    .o_dest_payload (dest_payload),
    .o_dest_keepin  (dest_keepin),
    .o_dest_last    (dest_last),
    .o_dest_cnt     (dest_cnt),
    .i_dest_ready   (dest_ready),
    .o_busy         (busy),
    .o_pkt_done     (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output handshakes and done pulses seen at each rising edge
  always @(posedge clk) begin
    if (dest_valid && dest_ready) beats <= beats + 1;
    if (pkt_done) dones <= dones + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] pay, input logic [3:0] keep,
                      input logic [1:0] cnt, input logic last);
    chk({tag, " valid"}, {31'd0, dest_valid}, 32'd1);
    chk({tag, " payload"}, dest_payload, pay);
    chk({tag, " keepin"}, {28'd0, dest_keepin}, {28'd0, keep});
    chk({tag, " cnt"}, {30'd0, dest_cnt}, {30'd0, cnt});
    chk({tag, " last"}, {31'd0, dest_last}, {31'd0, last});
  endtask

  // Advance one clock; inputs are changed and outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0;
    data_valid = 1'b0; data_payload = 32'd0; dest_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst data_ready", {31'd0, data_ready}, 32'd0);
    chk("rst dest_valid", {31'd0, dest_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst keepin", {28'd0, dest_keepin}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // len=10: two full beats and a 2-byte tail
    beats_base = beats; dones_base = dones;
    cmd_valid = 1'b1; cmd_len = 16'd10; #1;
    chk("p10 cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'h03020100; #1;
    chk("p10 data_ready", {31'd0, data_ready}, 32'd1);
    chk("p10 busy", {31'd0, busy}, 32'd1);
    step();
    beat("p10 b1", 32'h03020100, 4'b1111, 2'd3, 1'b0);
    data_payload = 32'h07060504;
    step();
    beat("p10 b2", 32'h07060504, 4'b1111, 2'd3, 1'b0);
    data_payload = 32'h0B0A0908;
    step();
    beat("p10 b3", 32'h00000908, 4'b0011, 2'd1, 1'b1);
    chk("p10 done pulse", {31'd0, pkt_done}, 32'd1);
    chk("p10 cmd_ready during tail", {31'd0, cmd_ready}, 32'd1);
    data_valid = 1'b0;
    step();
    chk("p10 drained", {31'd0, dest_valid}, 32'd0);
    chk("p10 done low", {31'd0, pkt_done}, 32'd0);
    chk("p10 beats", beats - beats_base, 32'd3);
    chk("p10 dones", dones - dones_base, 32'd1);

    // len=4 single full last beat, then len=0 discarded
    beats_base = beats; dones_base = dones;
    cmd_valid = 1'b1; cmd_len = 16'd4;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'hDDCCBBAA;
    step();
    beat("p4", 32'hDDCCBBAA, 4'b1111, 2'd3, 1'b1);
    data_valid = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_len = 16'd0;
    step();
    cmd_valid = 1'b0; #1;
    chk("p0 cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("p0 data_ready", {31'd0, data_ready}, 32'd0);
    chk("p0 busy", {31'd0, busy}, 32'd0);
    step();
    chk("p0 no beat", {31'd0, dest_valid}, 32'd0);
    chk("p4+p0 beats", beats - beats_base, 32'd1);
    chk("p4+p0 dones", dones - dones_base, 32'd1);

    // len=12 with a five-cycle downstream stall on beat 2
    beats_base = beats; dones_base = dones;
    cmd_valid = 1'b1; cmd_len = 16'd12;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'h11111111;
    step();
    beat("p12 b1", 32'h11111111, 4'b1111, 2'd3, 1'b0);
    data_payload = 32'h22222222;
    step();
    dest_ready = 1'b0; data_payload = 32'h33333333; #1;
    for (int i = 0; i < 5; i++) begin
      beat("p12 stall", 32'h22222222, 4'b1111, 2'd3, 1'b0);
      chk("p12 stall data_ready", {31'd0, data_ready}, 32'd0);
      step();
    end
    dest_ready = 1'b1; #1;
    chk("p12 release data_ready", {31'd0, data_ready}, 32'd1);
    step();
    beat("p12 b3", 32'h33333333, 4'b1111, 2'd3, 1'b1);
    data_valid = 1'b0;
    step();
    chk("p12 beats", beats - beats_base, 32'd3);
    chk("p12 dones", dones - dones_base, 32'd1);

    // Back-to-back len=1 then len=5 with one bubble between packets
    beats_base = beats; dones_base = dones;
    cmd_valid = 1'b1; cmd_len = 16'd1;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'h44434241;
    step();
    beat("p1", 32'h00000041, 4'b0001, 2'd0, 1'b1);
    cmd_valid = 1'b1; cmd_len = 16'd5; data_payload = 32'h58575655; #1;
    chk("b2b data_ready idle", {31'd0, data_ready}, 32'd0);
    chk("b2b cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0; #1;
    chk("b2b bubble", {31'd0, dest_valid}, 32'd0);
    chk("b2b data_ready", {31'd0, data_ready}, 32'd1);
    step();
    beat("p5 b1", 32'h58575655, 4'b1111, 2'd3, 1'b0);
    data_payload = 32'h5C5B5A59;
    step();
    beat("p5 b2", 32'h00000059, 4'b0001, 2'd0, 1'b1);
    data_valid = 1'b0;
    step();
    chk("b2b beats", beats - beats_base, 32'd3);
    chk("b2b dones", dones - dones_base, 32'd2);

    // Reset mid-packet, then a clean len=8 packet
    beats_base = beats; dones_base = dones;
    cmd_valid = 1'b1; cmd_len = 16'd12;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'h66666666;
    step();
    beat("abort b1", 32'h66666666, 4'b1111, 2'd3, 1'b0);
    dest_ready = 1'b0; rst_n = 1'b0; #1;
    chk("abort dest_valid", {31'd0, dest_valid}, 32'd0);
    chk("abort payload", dest_payload, 32'd0);
    chk("abort keepin", {28'd0, dest_keepin}, 32'd0);
    chk("abort last", {31'd0, dest_last}, 32'd0);
    chk("abort cnt", {30'd0, dest_cnt}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort data_ready", {31'd0, data_ready}, 32'd0);
    chk("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
    data_valid = 1'b0; dest_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("abort no last", dones - dones_base, 32'd0);
    cmd_valid = 1'b1; cmd_len = 16'd8;
    step();
    cmd_valid = 1'b0; data_valid = 1'b1; data_payload = 32'hA4A3A2A1;
    step();
    beat("p8 b1", 32'hA4A3A2A1, 4'b1111, 2'd3, 1'b0);
    data_payload = 32'hB4B3B2B1;
    step();
    beat("p8 b2", 32'hB4B3B2B1, 4'b1111, 2'd3, 1'b1);
    data_valid = 1'b0;
    step();
    chk("p8 dones", dones - dones_base, 32'd1);
    chk("p8 idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
